// File: rtl/rv32i_types.sv
// Shared rename/dispatch types: instruction, physical-register, dispatch-entry and output-group records.
package rv32i_types;

  localparam int MAX_SS = 4;
  localparam int PHYS_W = 8;
  localparam int ROB_W  = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic        regf_we;
    logic [1:0]  execute_operand1;
    logic [1:0]  execute_operand2;
    logic [31:0] imm;
    logic [3:0]  alu_op;
  } instruction_info_reg_t;

  typedef struct packed {
    logic             dependency;
    logic [ROB_W-1:0] ROB_ID;
  } physical_reg_data_t;

  typedef struct packed {
    logic [PHYS_W-1:0] rs1;
    logic [PHYS_W-1:0] rs2;
    logic [PHYS_W-1:0] rd;
  } rat_entry_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_t;

  typedef struct packed {
    instruction_info_reg_t inst_info;
    rat_entry_t            rat;
    logic [ROB_W-1:0]      rob_id;
    logic [ROB_W-1:0]      rs1_source;
    logic [ROB_W-1:0]      rs2_source;
    logic                  input1_met;
    logic                  input2_met;
    rvfi_t                 rvfi;
  } super_dispatch_t;

  typedef struct packed {
    logic [MAX_SS-1:0]                  lane_valid;
    super_dispatch_t [MAX_SS-1:0]       entries;
  } out_group_t;

  // A lane claims a new physical register only when it really writes an architectural one.
  function automatic logic writes_reg(input instruction_info_reg_t i);
    return i.valid & i.regf_we & (i.rd_s != 5'd0);
  endfunction

endpackage

// File: rtl/rename_dispatch_stage_group_dep_resolver.sv
// Combinational intra-group analysis: lane ranks, counts, RAW bypass selects and youngest-writer mask.
module group_dep_resolver #(
  parameter  int SS = 2,
  localparam int LW = (SS > 1) ? $clog2(SS) : 1,
  localparam int CW = $clog2(SS + 1)
) (
  input  logic [SS-1:0] live,
  input  logic [SS-1:0] writer,
  input  logic [4:0]    rd_s     [SS],
  input  logic [4:0]    rs1_s    [SS],
  input  logic [4:0]    rs2_s    [SS],
  output logic [LW-1:0] live_rank[SS],
  output logic [LW-1:0] wr_rank  [SS],
  output logic [CW-1:0] n_live,
  output logic [CW-1:0] n_wr,
  output logic [SS-1:0] byp1_hit,
  output logic [SS-1:0] byp2_hit,
  output logic [LW-1:0] byp1_sel [SS],
  output logic [LW-1:0] byp2_sel [SS],
  output logic [SS-1:0] youngest
);

  always_comb begin
    n_live   = '0;
    n_wr     = '0;
    byp1_hit = '0;
    byp2_hit = '0;
    youngest = '0;
    for (int i = 0; i < SS; i++) begin
      live_rank[i] = LW'(n_live);
      wr_rank[i]   = LW'(n_wr);
      n_live       = n_live + CW'(live[i]);
      n_wr         = n_wr + CW'(writer[i]);
      byp1_sel[i]  = '0;
      byp2_sel[i]  = '0;
      // Ascending scan: the last match is the closest older writer.
      for (int m = 0; m < i; m++) begin
        if (writer[m] && rd_s[m] == rs1_s[i] && rs1_s[i] != 5'd0) begin
          byp1_hit[i] = 1'b1;
          byp1_sel[i] = LW'(m);
        end
        if (writer[m] && rd_s[m] == rs2_s[i] && rs2_s[i] != 5'd0) begin
          byp2_hit[i] = 1'b1;
          byp2_sel[i] = LW'(m);
        end
      end
      youngest[i] = writer[i];
      for (int m = i + 1; m < SS; m++) begin
        if (writer[m] && rd_s[m] == rd_s[i]) youngest[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rename_dispatch_stage.sv
// Rename/dispatch stage: renames an SS-wide group through the RAT, resolves in-group RAW hazards and registers it for the backend.
module rename_dispatch_stage
  import rv32i_types::*;
#(
  parameter  int SS         = 2,
  parameter  int PR_ENTRIES = 64,
  parameter  int ROB_DEPTH  = 8,
  localparam int PRW        = $clog2(PR_ENTRIES),
  localparam int RIW        = $clog2(ROB_DEPTH),
  localparam int CW         = $clog2(SS + 1),
  localparam int LW         = (SS > 1) ? $clog2(SS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [63:0]           flush_order,
  input  logic                  iq_valid,
  output logic                  iq_ready,
  input  instruction_info_reg_t iq_inst     [SS],
  input  logic [PRW:0]          fl_count,
  input  logic [PRW-1:0]        fl_rd       [SS],
  output logic [CW-1:0]         fl_pop_cnt,
  input  logic [RIW:0]          rob_space,
  input  logic [RIW-1:0]        rob_id_next [SS],
  input  logic [RIW:0]          rs_space,
  output logic [4:0]            isa_rs1     [SS],
  output logic [4:0]            isa_rs2     [SS],
  input  logic [PRW-1:0]        rat_rs1     [SS],
  input  logic [PRW-1:0]        rat_rs2     [SS],
  output logic                  rat_we      [SS],
  output logic [4:0]            isa_rd      [SS],
  output logic [PRW-1:0]        rat_rd      [SS],
  output logic [PRW-1:0]        pr_rs1_s    [SS],
  output logic [PRW-1:0]        pr_rs2_s    [SS],
  input  physical_reg_data_t    pr_rs1      [SS],
  input  physical_reg_data_t    pr_rs2      [SS],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_lane_valid [SS],
  output super_dispatch_t       rs_rob_entry   [SS]
);

  logic [SS-1:0]     live, writer;
  logic [4:0]        rd_s [SS], rs1_s [SS], rs2_s [SS];
  logic [LW-1:0]     live_rank [SS], wr_rank [SS], byp1_sel [SS], byp2_sel [SS];
  logic [CW-1:0]     n_live, n_wr;
  logic [SS-1:0]     byp1_hit, byp2_hit, youngest;
  logic [PHYS_W-1:0] new_rd [SS];
  logic [ROB_W-1:0]  lane_rob [SS];
  logic              accept;
  logic [63:0]       order_ctr;
  out_group_t        grp_q, grp_d;

  always_comb begin
    for (int i = 0; i < SS; i++) begin
      live[i]   = iq_inst[i].valid;
      writer[i] = writes_reg(iq_inst[i]);
      rd_s[i]   = iq_inst[i].rd_s;
      rs1_s[i]  = iq_inst[i].rs1_s;
      rs2_s[i]  = iq_inst[i].rs2_s;
    end
  end

  group_dep_resolver #(.SS(SS)) u_resolver (
    .live      (live),
    .writer    (writer),
    .rd_s      (rd_s),
    .rs1_s     (rs1_s),
    .rs2_s     (rs2_s),
    .live_rank (live_rank),
    .wr_rank   (wr_rank),
    .n_live    (n_live),
    .n_wr      (n_wr),
    .byp1_hit  (byp1_hit),
    .byp2_hit  (byp2_hit),
    .byp1_sel  (byp1_sel),
    .byp2_sel  (byp2_sel),
    .youngest  (youngest)
  );

  // Handshake: a group transfers when iq_valid && iq_ready; iq_ready is only raised when the
  // output register can take it (empty or draining) and every backend resource has room.
  assign accept = rst_n & iq_valid & ~flush & (~out_valid | out_ready)
                & (fl_count >= (PRW+1)'(n_wr))
                & (rob_space >= (RIW+1)'(n_live))
                & (rs_space >= (RIW+1)'(n_live));
  assign iq_ready   = accept;
  assign fl_pop_cnt = accept ? n_wr : '0;

  always_comb begin
    for (int i = 0; i < SS; i++) begin
      isa_rs1[i]  = rs1_s[i];
      isa_rs2[i]  = rs2_s[i];
      pr_rs1_s[i] = rat_rs1[i];
      pr_rs2_s[i] = rat_rs2[i];
      isa_rd[i]   = rd_s[i];
      rat_rd[i]   = writer[i] ? fl_rd[wr_rank[i]] : '0;
      rat_we[i]   = accept & youngest[i];
      new_rd[i]   = PHYS_W'(rat_rd[i]);
      lane_rob[i] = ROB_W'(rob_id_next[live_rank[i]]);
    end
  end

  always_comb begin
    grp_d = '0;
    for (int i = 0; i < SS; i++) begin
      grp_d.lane_valid[i]         = live[i];
      grp_d.entries[i].inst_info  = iq_inst[i];
      grp_d.entries[i].rob_id     = lane_rob[i];
      grp_d.entries[i].rat.rd     = new_rd[i];
      if (byp1_hit[i]) begin
        grp_d.entries[i].rat.rs1    = new_rd[byp1_sel[i]];
        grp_d.entries[i].rs1_source = lane_rob[byp1_sel[i]];
        grp_d.entries[i].input1_met = 1'b0;
      end else begin
        grp_d.entries[i].rat.rs1    = PHYS_W'(rat_rs1[i]);
        grp_d.entries[i].rs1_source = pr_rs1[i].ROB_ID;
        grp_d.entries[i].input1_met = ~pr_rs1[i].dependency;
      end
      if (byp2_hit[i]) begin
        grp_d.entries[i].rat.rs2    = new_rd[byp2_sel[i]];
        grp_d.entries[i].rs2_source = lane_rob[byp2_sel[i]];
        grp_d.entries[i].input2_met = 1'b0;
      end else begin
        grp_d.entries[i].rat.rs2    = PHYS_W'(rat_rs2[i]);
        grp_d.entries[i].rs2_source = pr_rs2[i].ROB_ID;
        grp_d.entries[i].input2_met = ~pr_rs2[i].dependency;
      end
      // Immediates and x0 never wait on a producer.
      if (iq_inst[i].execute_operand1[0] || rs1_s[i] == 5'd0) grp_d.entries[i].input1_met = 1'b1;
      if (iq_inst[i].execute_operand2[0] || rs2_s[i] == 5'd0) grp_d.entries[i].input2_met = 1'b1;
      grp_d.entries[i].rvfi.valid    = live[i];
      grp_d.entries[i].rvfi.order    = order_ctr + 64'(live_rank[i]);
      grp_d.entries[i].rvfi.inst     = iq_inst[i].inst;
      grp_d.entries[i].rvfi.rs1_addr = rs1_s[i];
      grp_d.entries[i].rvfi.rs2_addr = rs2_s[i];
      grp_d.entries[i].rvfi.rd_addr  = rd_s[i];
      grp_d.entries[i].rvfi.pc_rdata = iq_inst[i].pc;
      grp_d.entries[i].rvfi.pc_wdata = iq_inst[i].pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      order_ctr <= '0;
      grp_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      order_ctr <= flush_order;
    end else if (accept) begin
      out_valid <= 1'b1;
      grp_q     <= grp_d;
      order_ctr <= order_ctr + 64'(n_live);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < SS; i++) begin
      out_lane_valid[i] = grp_q.lane_valid[i];
      rs_rob_entry[i]   = grp_q.entries[i];
    end
  end

  // Group record is sized for the widest configuration; lanes beyond SS stay at reset value.
  for (genvar g = SS; g < MAX_SS; g++) begin : g_spare_lane
    logic unused_lane;
    assign unused_lane = ^{grp_q.lane_valid[g], grp_q.entries[g]};
  end

endmodule

// File: doc/rename_dispatch_stage.md
# rename_dispatch_stage

Parametrised, pipelined rename/dispatch stage between the instruction queue and the ROB/reservation stations. Each cycle it accepts an SS-wide instruction group atomically, with a valid/ready handshake, when the free list, ROB and RS all have room. It renames through the RAT, resolves dependencies within the group, assigns RVFI order, and registers one fully built `super_dispatch_t` group per cycle for the backend. Unlike the first-generation dispatcher, it does the following:

- stalls on resource counts;
- pops the free list only for lanes that write a register;
- bypasses intra-group RAW hazards;
- supports flush.

## Interface
Parameters:
- SS, 2, lanes per group (1–4)
- PR_ENTRIES, 64, physical registers; PRW = $clog2(PR_ENTRIES)
- ROB_DEPTH, 8, ROB entries; RIW = $clog2(ROB_DEPTH)

Ports (the `[SS]` arrays are unpacked arrays with one element per lane):
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  pipeline flush from ROB
- flush_order  in  64  order value to resume from after flush
- iq_valid  in  1  group available
- iq_ready  out  1  group accepted this cycle (combinational)
- iq_inst  in  instruction_info_reg_t [SS]  group; `.valid` marks live lanes
- fl_count  in  PRW+1  free-list occupancy
- fl_rd  in  PRW [SS]  free-list entries head+0 … head+SS-1
- fl_pop_cnt  out  $clog2(SS+1)  entries popped this cycle
- rob_space  in  RIW+1  free ROB slots
- rob_id_next  in  RIW [SS]  ROB ids for head+0 … head+SS-1
- rs_space  in  RIW+1  free RS slots
- isa_rs1, isa_rs2  out  5 [SS]  RAT read addresses
- rat_rs1, rat_rs2  in  PRW [SS]  RAT read data (combinational)
- rat_we  out  [SS]  RAT write enables
- isa_rd  out  5 [SS]  RAT write address
- rat_rd  out  PRW [SS]  RAT write data
- pr_rs1_s, pr_rs2_s  out  PRW [SS]  physical reg file read addresses
- pr_rs1, pr_rs2  in  physical_reg_data_t [SS]  `.dependency` and `.ROB_ID` (combinational)
- out_valid  out  1  registered group valid
- out_ready  in  1  ROB/RS accept the group
- out_lane_valid  out  [SS]  live lanes of the output group
- rs_rob_entry  out  super_dispatch_t [SS]  output group

## Operation
- Counts:
  - n_live = popcount(iq_inst[i].valid).
  - n_wr = count of live lanes with rd_s ≠ 0 and regfile write enabled.
- accept = iq_valid & ~flush & (~out_valid | out_ready) & fl_count ≥ n_wr & rob_space ≥ n_live & rs_space ≥ n_live.
- iq_ready = accept.
- fl_pop_cnt = accept ? n_wr : 0.
- Free-list slots: writer lane i takes fl_rd[k], where k = number of writer lanes below i.
- Non-writer lanes: rat.rd = 0. They do not consume a free-list entry.
- ROB ids: live lane i takes rob_id_next[j], where j = number of live lanes below i.
- Intra-group bypass: for lane i, source rsX, find the highest writer lane m < i with rd_s = rsX_s ≠ 0.
  - If found: rat.rsX = renamed rd of lane m, rsX_source = ROB id of lane m, inputX_met = 0.
  - Otherwise: use rat_rsX and pr_rsX.
- inputX_met = 1 if execute_operandX[0] is set (immediate) or rsX_s = 0. Otherwise it is ~dependency, or 0 when bypassed.
- RAT writes: rat_we[i] = accept & lane i writer & no higher writer lane with the same rd_s, so the youngest writer wins.
- RVFI:
  - valid = lane valid.
  - order = order_ctr + j, where j is the live-lane rank.
  - addresses and PCs are taken from the instruction.
  - mem masks = 0; data fields = 0.
  - order_ctr += n_live on accept.
- State:
  - {out_valid, out group, order_ctr}.
  - Load on accept.
  - Clear out_valid on out_ready with no accept.
  - Hold otherwise.
- Flush has priority:
  - out_valid ← 0, order_ctr ← flush_order.
  - No accept, no pops and no RAT writes that cycle.

## Timing
- Reset (async assert, sync deassert):
  - out_valid = 0, order_ctr = 0.
  - rs_rob_entry and out_lane_valid = 0.
  - Combinational outputs: iq_ready = 0 and fl_pop_cnt = 0, because accept is gated by rst_n.
- Latency: accept in cycle t gives out_valid in cycle t+1.
- Throughput: one group per cycle while out_ready is high.
- Back-pressure:
  - out_valid & ~out_ready: the output is held stable, iq_ready = 0.
  - out_valid & out_ready in the same cycle as accept: the register refills with no bubble.
- Resource boundaries:
  - fl_count = n_wr exactly: accepted.
  - fl_count = n_wr − 1: stall, zero pops.
  - n_live = 0 with iq_valid: accepted as an empty group; order_ctr is unchanged.
- Reset mid-stall drops the held group.

## Structure
- Shared types and constants go in rv32i_types:
  - super_dispatch_t, physical_reg_data_t, instruction_info_reg_t.
  - New out_group_t (lane-valid mask plus entries).
- One sub-module: group_dep_resolver. It is combinational and produces the rank, bypass-select and youngest-writer masks for SS lanes.

## Test plan
- Reset low mid-stream with out_valid = 1 → out_valid = 0, iq_ready = 0, order_ctr = 0 asynchronously.
- Group {add x5 ← x1,x2 ; add x6 ← x5,x3}, fl_rd = {40, 41} → lane1 rat.rs1 = 40, input1_met = 0, rs1_source = lane0 ROB id, fl_pop_cnt = 2.
- Group {sw ; add x7} → lane1 rat.rd = fl_rd[0], fl_pop_cnt = 1, lane0 rat.rd = 0.
- Both lanes write x9 → rat_we = 01b→10b (lane1 only), both lanes get distinct PRs.
- fl_count = 1 with 2 writers → iq_ready = 0 and no pops. fl_count = 2 → accept, out_valid next cycle.
- Hold out_ready = 0 for 3 cycles, then assert flush with flush_order = 100 → out_valid = 0. The next accepted group's orders are 100 and 101.
